ps2_key_decoder: RTL and testbench

- Receives PS/2 keyboard frames and turns scan-code set 2 make/break sequences into the 5-bit KEY_PRESSED code used by the direction logic.
- Codes 0-15 select a player direction, and code 16 requests a game reset.
- Sits between the board PS/2 pins and the direction-latch stage, in the CLOCK_50 domain.

---
 rtl/ps2_key_decoder.sv | 197 +++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and scan-code set 2 decoder producing the 5-bit
// KEY_PRESSED direction/reset code, with make/break tracking and frame checks.
module ps2_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter logic [4:0]  IDLE_CODE      = 5'd31
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [4:0] KEY_PRESSED,
  output logic       key_valid,
  output logic       frame_err
);

  localparam int unsigned TMO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

  logic [1:0]        clk_sync_q, clk_sync_d;
  logic [1:0]        dat_sync_q, dat_sync_d;
  logic              clk_prev_q, clk_prev_d;
  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              byte_vld_q, byte_vld_d;
  logic              ext_q, ext_d;
  logic              brk_q, brk_d;
  logic [4:0]        key_q, key_d;
  logic              key_valid_q, key_valid_d;
  logic              frame_err_q, frame_err_d;

  logic              fall_c;
  logic              dat_c;
  logic              tmo_hit_c;
  logic [5:0]        lkp_c;

  // Returns {hit, code} for a (extended, byte) pair.
  function automatic logic [5:0] lookup_code(input logic ext, input logic [BYTE_W-1:0] b);
    logic [5:0] res;
    res = 6'd0;
    case ({ext, b})
      9'h01D: res = {1'b1, 5'd0};
      9'h01B: res = {1'b1, 5'd1};
      9'h01C: res = {1'b1, 5'd2};
      9'h023: res = {1'b1, 5'd3};
      9'h043: res = {1'b1, 5'd4};
      9'h042: res = {1'b1, 5'd5};
      9'h03B: res = {1'b1, 5'd6};
      9'h04B: res = {1'b1, 5'd7};
      9'h175: res = {1'b1, 5'd8};
      9'h172: res = {1'b1, 5'd9};
      9'h16B: res = {1'b1, 5'd10};
      9'h174: res = {1'b1, 5'd11};
      9'h075: res = {1'b1, 5'd12};
      9'h073: res = {1'b1, 5'd13};
      9'h06B: res = {1'b1, 5'd14};
      9'h074: res = {1'b1, 5'd15};
      9'h029: res = {1'b1, 5'd16};
      default: res = 6'd0;
    endcase
    return res;
  endfunction

  assign fall_c    = clk_prev_q & ~clk_sync_q[1];
  assign dat_c     = dat_sync_q[1];
  assign tmo_hit_c = (state_q != IDLE) && !fall_c &&
                     (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign lkp_c     = lookup_code(ext_q, shift_q);

  always_comb begin
    clk_sync_d  = {clk_sync_q[0], PS2_CLK};
    dat_sync_d  = {dat_sync_q[0], PS2_DAT};
    clk_prev_d  = clk_sync_q[1];
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    tmo_cnt_d   = tmo_cnt_q;
    byte_vld_d  = 1'b0;
    ext_d       = ext_q;
    brk_d       = brk_q;
    key_d       = key_q;
    key_valid_d = 1'b0;
    frame_err_d = 1'b0;

    // Byte decoder; shift_q still holds the byte delivered on the previous cycle.
    if (byte_vld_q) begin
      if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        if (lkp_c[5]) begin
          if (brk_q) begin
            if (key_q == lkp_c[4:0]) key_d = IDLE_CODE;
          end else begin
            key_d       = lkp_c[4:0];
            key_valid_d = 1'b1;
          end
        end
        ext_d = 1'b0;
        brk_d = 1'b0;
      end
    end

    if (fall_c || state_q == IDLE || tmo_hit_c) tmo_cnt_d = '0;
    else                                        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);

    if (fall_c) begin
      case (state_q)
        IDLE: begin
          if (!dat_c) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d   = {dat_c, shift_q[BYTE_W-1:1]};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(7)) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_c;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (dat_c && (^{par_q, shift_q})) begin
            byte_vld_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Stalled partial frame: abandon it and forget any pending prefix.
    if (tmo_hit_c) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
      ext_d       = 1'b0;
      brk_d       = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      clk_sync_q  <= 2'b11;
      dat_sync_q  <= 2'b11;
      clk_prev_q  <= 1'b1;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tmo_cnt_q   <= '0;
      byte_vld_q  <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      key_q       <= IDLE_CODE;
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      dat_sync_q  <= dat_sync_d;
      clk_prev_q  <= clk_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tmo_cnt_q   <= tmo_cnt_d;
      byte_vld_q  <= byte_vld_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign KEY_PRESSED = key_q;
  assign key_valid   = key_valid_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: PS/2 frames are bit-banged and every
// key_valid/frame_err pulse is matched against a queue of expected events.
module tb_ps2_key_decoder;

  localparam int unsigned TMO  = 400;
  localparam int unsigned HALF = 8;
  localparam int unsigned GAP  = 24;

  logic       CLOCK_50;
  logic       resetn;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic [4:0] KEY_PRESSED;
  logic       key_valid;
  logic       frame_err;

  int         n_cmp;
  int         n_err;
  logic [6:0] exp_q[$];
  logic [4:0] model_key;

  ps2_key_decoder #(
    .TIMEOUT_CYCLES(TMO),
    .IDLE_CODE     (5'd31)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .resetn     (resetn),
    .PS2_CLK    (PS2_CLK),
    .PS2_DAT    (PS2_DAT),
    .KEY_PRESSED(KEY_PRESSED),
    .key_valid  (key_valid),
    .frame_err  (frame_err)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check_val(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock; any output pulse is popped against the event scoreboard.
  task automatic tick();
    logic [6:0] obs;
    logic [6:0] exp;
    @(posedge CLOCK_50);
    #1;
    if (key_valid || frame_err) begin
      obs = {frame_err, key_valid, KEY_PRESSED};
      exp = (exp_q.size() == 0) ? 7'd0 : exp_q.pop_front();
      check_val("event", obs, exp);
    end
  endtask

  task automatic exp_make(input logic [4:0] code);
    exp_q.push_back({2'b01, code});
    model_key = code;
  endtask

  task automatic exp_err();
    exp_q.push_back({2'b10, model_key});
  endtask

  task automatic check_key(input string tag, input logic [4:0] code);
    model_key = code;
    check_val(tag, 7'(KEY_PRESSED), 7'(code));
    check_val({tag, "_pending"}, 7'(exp_q.size()), 7'd0);
  endtask

  task automatic send_bit(input logic b);
    PS2_DAT = b;
    repeat (HALF) tick();
    PS2_CLK = 1'b0;
    repeat (HALF) tick();
    PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~(^b) ^ par_flip);
    send_bit(stop);
    repeat (GAP) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1);
  endtask

  task automatic make_key(input logic ext, input logic [7:0] b, input logic [4:0] code);
    exp_make(code);
    if (ext) send_byte(8'hE0);
    send_byte(b);
    check_key("table", code);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    model_key = 5'd31;
    resetn    = 1'b0;
    PS2_CLK   = 1'b1;
    PS2_DAT   = 1'b1;
    repeat (3) tick();
    check_val("rst_key", 7'(KEY_PRESSED), 7'd31);
    check_val("rst_kv", 7'(key_valid), 7'd0);
    check_val("rst_fe", 7'(frame_err), 7'd0);
    resetn = 1'b1;
    repeat (4) tick();

    // Make and break of W.
    exp_make(5'd0);
    send_byte(8'h1D);
    check_key("make_w", 5'd0);
    send_byte(8'hF0);
    send_byte(8'h1D);
    check_key("break_w", 5'd31);

    // Extended arrow versus keypad 8 share byte 75.
    exp_make(5'd8);
    send_byte(8'hE0);
    send_byte(8'h75);
    check_key("ext_up", 5'd8);
    exp_make(5'd12);
    send_byte(8'h75);
    check_key("kp8", 5'd12);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    check_key("ext_brk_other", 5'd12);
    send_byte(8'hF0);
    send_byte(8'h75);
    check_key("kp8_brk", 5'd31);

    // Overlapping keys: latest make wins.
    exp_make(5'd2);
    send_byte(8'h1C);
    exp_make(5'd4);
    send_byte(8'h43);
    send_byte(8'hF0);
    send_byte(8'h1C);
    check_key("old_release", 5'd4);
    send_byte(8'hF0);
    send_byte(8'h43);
    check_key("new_release", 5'd31);

    // Remaining table entries, plus a typematic repeat.
    make_key(1'b0, 8'h1B, 5'd1);
    make_key(1'b0, 8'h23, 5'd3);
    make_key(1'b0, 8'h42, 5'd5);
    make_key(1'b0, 8'h3B, 5'd6);
    make_key(1'b0, 8'h4B, 5'd7);
    make_key(1'b1, 8'h72, 5'd9);
    make_key(1'b1, 8'h6B, 5'd10);
    make_key(1'b1, 8'h74, 5'd11);
    make_key(1'b0, 8'h73, 5'd13);
    make_key(1'b0, 8'h74, 5'd15);
    make_key(1'b0, 8'h6B, 5'd14);
    make_key(1'b0, 8'h6B, 5'd14);
    make_key(1'b0, 8'h29, 5'd16);

    // Unmapped and E0-prefixed non-arrow bytes change nothing but the flags.
    send_byte(8'h5A);
    check_key("unmapped", 5'd16);
    send_byte(8'hE0);
    send_byte(8'h1D);
    check_key("ext_unmapped", 5'd16);
    make_key(1'b0, 8'h1D, 5'd0);

    // Parity error drops the byte and the pending break.
    send_byte(8'hF0);
    exp_err();
    send_frame(8'h23, 1'b1, 1'b1);
    check_key("par_err", 5'd0);
    make_key(1'b0, 8'h1C, 5'd2);
    exp_err();
    send_frame(8'h23, 1'b0, 1'b0);
    check_key("stop_err", 5'd2);

    // Stalled partial frame times out.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    exp_err();
    repeat (TMO + 40) tick();
    check_key("timeout", 5'd2);
    make_key(1'b0, 8'h29, 5'd16);

    // Reset during the data bits of 4B.
    make_key(1'b0, 8'h42, 5'd5);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    check_key("rst_mid", 5'd31);
    // Leftover bits 1,0,0,1,0,par 1,stop 1: the first 0 looks like a start bit
    // and the stub frame stalls in DATA until the timeout fires.
    exp_err();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    repeat (TMO + 40) tick();
    check_key("rst_leftover", 5'd31);
    make_key(1'b0, 8'h4B, 5'd7);

    repeat (10) tick();
    check_val("drain", 7'(exp_q.size()), 7'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
